// File: rtl/priority_arbiter.sv
// priority_arbiter
//   Registered arbiter over 2**N request lines, fixed-priority or round-robin,
//   presenting one winner at a time behind a valid/ready handshake.
//
// Handshake: a grant is offered while grant_valid-equivalent grantValid is high;
//   it is accepted on the rising edge where grantValid && grantReady. Until that
//   edge all grant outputs hold regardless of req/mode/enable. grantReady is
//   ignored while no grant is offered.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   enable       new grants are issued only while high
//   mode         0 = fixed priority (highest index wins), 1 = round robin
//   req          request vector, one bit per requester
//   grantReady   consumer accepts the current grant
//   grantValid   grant outputs hold a valid winner
//   grantIdx     binary index of the winner (0 when idle)
//   grantOneHot  one-hot winner (0 when idle)
//   lastIdx      index of the most recently accepted grant
//   state_dbg    current FSM state (0 = IDLE, 1 = GRANT)
module priority_arbiter #(
  parameter int N = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                mode,
  input  logic [(2**N)-1:0]   req,
  input  logic                grantReady,
  output logic                grantValid,
  output logic [N-1:0]        grantIdx,
  output logic [(2**N)-1:0]   grantOneHot,
  output logic [N-1:0]        lastIdx,
  output logic                state_dbg
);

  localparam int NUM = 2**N;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t state;

  logic [N-1:0] search_base;
  logic [N-1:0] search_idx;
  logic [N-1:0] cand_idx;
  logic         cand_found;
  logic         accept;

  assign accept    = (state == GRANT) && grantReady;
  assign state_dbg = (state == GRANT);

  // The only capture out of GRANT happens on accept, where the pointer being
  // written is the grant itself, so the search base can use grantIdx directly
  // and the back-to-back search sees the updated pointer. Fixed mode is the
  // round-robin search with base 0.
  always_comb begin
    search_base = '0;
    if (mode) begin
      search_base = (state == GRANT) ? grantIdx : lastIdx;
    end
  end

  // Descending search base-1, base-2, ... with modulo-2**N wrap; base is last.
  always_comb begin
    cand_found = 1'b0;
    cand_idx   = '0;
    search_idx = '0;
    for (int k = 1; k <= NUM; k++) begin
      search_idx = search_base - k[N-1:0];
      if (!cand_found && req[search_idx]) begin
        cand_found = 1'b1;
        cand_idx   = search_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      grantValid  <= 1'b0;
      grantIdx    <= '0;
      grantOneHot <= '0;
      lastIdx     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (enable && cand_found) begin
            state       <= GRANT;
            grantValid  <= 1'b1;
            grantIdx    <= cand_idx;
            grantOneHot <= NUM'(1) << cand_idx;
          end
        end
        GRANT: begin
          if (accept) begin
            lastIdx <= grantIdx;
            if (enable && cand_found) begin
              grantIdx    <= cand_idx;
              grantOneHot <= NUM'(1) << cand_idx;
            end else begin
              state       <= IDLE;
              grantValid  <= 1'b0;
              grantIdx    <= '0;
              grantOneHot <= '0;
            end
          end
        end
        default: begin
          state       <= IDLE;
          grantValid  <= 1'b0;
          grantIdx    <= '0;
          grantOneHot <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_priority_arbiter.sv
module tb_priority_arbiter;

  localparam int N   = 3;
  localparam int NUM = 2**N;

  logic           clk;
  logic           rst_n;
  logic           enable;
  logic           mode;
  logic [NUM-1:0] req;
  logic           grant_ready;
  logic           grant_valid;
  logic [N-1:0]   grant_idx;
  logic [NUM-1:0] grant_one_hot;
  logic [N-1:0]   last_idx;
  logic           state_dbg;

  int checks;
  int errors;

  priority_arbiter #(.N(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .mode        (mode),
    .req         (req),
    .grantReady  (grant_ready),
    .grantValid  (grant_valid),
    .grantIdx    (grant_idx),
    .grantOneHot (grant_one_hot),
    .lastIdx     (last_idx),
    .state_dbg   (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; inputs are driven and outputs sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    enable      = 1'b0;
    mode        = 1'b0;
    req         = '0;
    grant_ready = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (grant_valid !== 1'b0 || grant_idx !== 3'd0 || grant_one_hot !== 8'h00 ||
        last_idx !== 3'd0 || state_dbg !== 1'b0) begin
      errors++;
      $display("FAIL reset_initial: valid=%b idx=%0d oh=%h last=%0d state=%b, need 0/0/00/0/0",
               grant_valid, grant_idx, grant_one_hot, last_idx, state_dbg);
    end
    // Accept one grant of 5, then leave a second grant of 5 pending.
    enable = 1'b1; mode = 1'b0; req = 8'h20; grant_ready = 1'b1;
    step();
    step();
    grant_ready = 1'b0;
    checks++;
    if (grant_valid !== 1'b1 || grant_idx !== 3'd5 || last_idx !== 3'd5) begin
      errors++;
      $display("FAIL reset_pending_setup: valid=%b idx=%0d last=%0d, need 1/5/5",
               grant_valid, grant_idx, last_idx);
    end
    // Assert reset mid-cycle, check before the next edge.
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (grant_valid !== 1'b0 || grant_idx !== 3'd0 || grant_one_hot !== 8'h00 ||
        last_idx !== 3'd0) begin
      errors++;
      $display("FAIL reset_async: valid=%b idx=%0d oh=%h last=%0d, need 0/0/00/0",
               grant_valid, grant_idx, grant_one_hot, last_idx);
    end
    req = '0;
    step();
    rst_n = 1'b1;
    step();
    step();
    step();
    checks++;
    if (grant_valid !== 1'b0 || state_dbg !== 1'b0) begin
      errors++;
      $display("FAIL reset_stay_idle: valid=%b state=%b, need 0/0", grant_valid, state_dbg);
    end
  endtask

  task automatic test_fixed();
    do_reset();
    enable = 1'b1; mode = 1'b0; req = 8'b0010_0110; grant_ready = 1'b1;
    step();
    checks++;
    if (grant_valid !== 1'b1 || grant_idx !== 3'd5 || grant_one_hot !== 8'h20) begin
      errors++;
      $display("FAIL fixed_first: valid=%b idx=%0d oh=%h, need 1/5/20",
               grant_valid, grant_idx, grant_one_hot);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (grant_valid !== 1'b1 || grant_idx !== 3'd5 || last_idx !== 3'd5) begin
        errors++;
        $display("FAIL fixed_repeat[%0d]: valid=%b idx=%0d last=%0d, need 1/5/5",
                 i, grant_valid, grant_idx, last_idx);
      end
    end
  endtask

  task automatic test_round_robin_all();
    logic [N-1:0] exp_seq [9];
    exp_seq = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd7};
    do_reset();
    enable = 1'b1; mode = 1'b1; req = 8'hFF; grant_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      step();
      checks++;
      if (grant_valid !== 1'b1 || grant_idx !== exp_seq[i] ||
          grant_one_hot !== (8'h01 << exp_seq[i])) begin
        errors++;
        $display("FAIL rr_all[%0d]: valid=%b idx=%0d oh=%h, need 1/%0d/%h",
                 i, grant_valid, grant_idx, grant_one_hot, exp_seq[i], 8'h01 << exp_seq[i]);
      end
    end
  endtask

  task automatic test_round_robin_pair_mode_switch();
    logic [N-1:0] exp_seq [4];
    exp_seq = '{3'd7, 3'd1, 3'd7, 3'd1};
    do_reset();
    enable = 1'b1; mode = 1'b1; req = 8'b1000_0010; grant_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (grant_idx !== exp_seq[i]) begin
        errors++;
        $display("FAIL rr_pair[%0d]: idx=%0d, need %0d", i, grant_idx, exp_seq[i]);
      end
    end
    mode = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (grant_valid !== 1'b1 || grant_idx !== 3'd7) begin
        errors++;
        $display("FAIL rr_to_fixed[%0d]: valid=%b idx=%0d, need 1/7", i, grant_valid, grant_idx);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    enable = 1'b1; mode = 1'b0; req = 8'h20; grant_ready = 1'b0;
    step();
    req = 8'h01;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (grant_valid !== 1'b1 || grant_idx !== 3'd5 || grant_one_hot !== 8'h20) begin
        errors++;
        $display("FAIL bp_hold[%0d]: valid=%b idx=%0d oh=%h, need 1/5/20",
                 i, grant_valid, grant_idx, grant_one_hot);
      end
    end
    grant_ready = 1'b1;
    step();
    grant_ready = 1'b0;
    checks++;
    if (grant_valid !== 1'b1 || grant_idx !== 3'd0 || grant_one_hot !== 8'h01 ||
        last_idx !== 3'd5) begin
      errors++;
      $display("FAIL bp_accept: valid=%b idx=%0d oh=%h last=%0d, need 1/0/01/5",
               grant_valid, grant_idx, grant_one_hot, last_idx);
    end
  endtask

  task automatic test_enable();
    do_reset();
    enable = 1'b0; mode = 1'b0; req = 8'h10; grant_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (grant_valid !== 1'b0) begin
        errors++;
        $display("FAIL en_off[%0d]: valid=%b, need 0", i, grant_valid);
      end
    end
    grant_ready = 1'b0;
    enable = 1'b1;
    step();
    enable = 1'b0;
    step();
    step();
    checks++;
    if (grant_valid !== 1'b1 || grant_idx !== 3'd4 || grant_one_hot !== 8'h10) begin
      errors++;
      $display("FAIL en_drop_hold: valid=%b idx=%0d oh=%h, need 1/4/10",
               grant_valid, grant_idx, grant_one_hot);
    end
    grant_ready = 1'b1;
    step();
    checks++;
    if (grant_valid !== 1'b0 || grant_idx !== 3'd0 || grant_one_hot !== 8'h00 ||
        last_idx !== 3'd4) begin
      errors++;
      $display("FAIL en_drop_accept: valid=%b idx=%0d oh=%h last=%0d, need 0/0/00/4",
               grant_valid, grant_idx, grant_one_hot, last_idx);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_fixed();
    test_round_robin_all();
    test_round_robin_pair_mode_switch();
    test_backpressure();
    test_enable();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/priority_arbiter.md
# priority_arbiter

Registered, parametrised successor to the combinational N-bit priority encoder. It arbitrates among 2**N request lines in either fixed-priority or round-robin mode. The winner is presented as a binary index plus a one-hot vector, behind a valid/ready handshake. It sits between request sources (interrupt or channel requesters) and a single consumer that accepts one grant at a time.

## Interface
- N, default 3: index width; number of request lines = 2**N (N >= 1).
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- enable  input  1  arbitration enable; new grants are issued only while high.
- mode  input  1  0 = fixed priority (highest index wins), 1 = round robin.
- req  input  2**N  request vector; bit i high = requester i wants service.
- grantReady  input  1  consumer accepts the current grant when high with grantValid.
- grantValid  output  1  grant outputs hold a valid winner.
- grantIdx  output  N  binary index of the winner.
- grantOneHot  output  2**N  one-hot winner: 1 << grantIdx when valid, 0 otherwise.
- lastIdx  output  N  index of the most recently accepted grant (round-robin pointer).

## Operation
- States: IDLE (grantValid=0) and GRANT (grantValid=1).
- Arbitration candidate: the winner from the current req/mode/lastIdx, evaluated combinationally each cycle. No candidate exists when req == 0.
- Fixed mode search order: 2**N-1 down to 0. The first set bit wins.
- Round-robin search order with L = lastIdx: L-1, L-2, …, 0, 2**N-1, …, L, descending with wrap. L is searched last. With L = 0 the order equals fixed order.
- IDLE -> GRANT: enable=1 and a candidate exists. Capture the candidate into grantIdx/grantOneHot and set grantValid.
- GRANT, grantReady=0: all grant outputs hold. Changes to req, mode or enable do not alter a pending grant.
- GRANT, grantReady=1 (accept):
  - lastIdx <= grantIdx, in both modes.
  - If enable=1 and a candidate exists, stay in GRANT and capture the new candidate. Its search uses the updated pointer, i.e. L = the grant being accepted (back-to-back issue).
  - Otherwise go to IDLE and clear grantValid, grantIdx and grantOneHot.
- grantReady while IDLE is ignored.
- A requester whose req bit drops while its grant is pending still keeps the grant until it is accepted.
- Mode changes take effect at the next capture and use the current lastIdx.
- Width rules:
  - grantIdx and lastIdx are N bits. The wrap from index 0 to 2**N-1 is modulo 2**N.
  - grantOneHot has exactly one bit set when grantValid=1, and is 0 otherwise.
- No simulation-only messaging in the synthesised block.

## Timing
- Reset (rst_n low, asynchronous, any state, including mid-grant):
  - State goes to IDLE.
  - grantValid=0, grantIdx=0, grantOneHot=0, lastIdx=0.
  - These values appear immediately, without waiting for a clock edge.
  - The first capture is possible on the first rising edge after rst_n deasserts.
- Latency: req/enable sampled at edge k -> grantValid/grantIdx valid after edge k (1 cycle).
- Throughput: one grant per cycle while grantReady is held high and requests persist.
- Accept occurs on the edge where grantValid=1 and grantReady=1. The outputs after that edge reflect the next grant, or IDLE.
- All outputs are registered. There is no combinational path from req/grantReady to any output.

## Test plan
- Reset: drive rst_n low during a pending grant (grantIdx=5) -> grantValid, grantIdx, grantOneHot and lastIdx all go to 0 without a clock edge. After release with req=0, the block stays IDLE.
- Fixed mode, N=3, enable=1, grantReady=1, req=8'b0010_0110 held -> grantIdx=5, grantOneHot=8'h20 one cycle later, then 5 every cycle. lastIdx=5.
- Round robin, req=8'hFF held, grantReady=1 -> grantIdx sequence 7,6,5,4,3,2,1,0,7 on consecutive cycles.
- Round robin, req=8'b1000_0010 -> grants alternate 7,1,7,1. Switching mode to 0 mid-run -> grants become 7,7,7.
- Backpressure: grant 5 pending, grantReady=0 for 3 cycles, req changed to 8'h01 -> grantIdx stays 5 and grantValid stays 1. Then one cycle of grantReady=1 -> next cycle grantIdx=0, lastIdx=5.
- Enable:
  - enable=0, req=8'h10 -> grantValid stays 0.
  - enable dropped while grant 4 is pending -> the grant holds until accepted, then grantValid=0 and grantOneHot=0.
